// File: rtl/recompute_unit_if.sv
// Recompute-request channel: request, weight/data buffer reads and result stream.
// The slave modport is the unit's side; master is the initiator/buffer/corrector side.
interface recompute_unit_if #(
  parameter int DATA_W = 8,
  parameter int RC_W   = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [RC_W-1:0]       req_row;
  logic [RC_W-1:0]       req_col;
  logic                  req_err;
  logic                  w_rd_en;
  logic [RC_W-1:0]       w_rd_row;
  logic [RC_W-1:0]       w_rd_col;
  logic [DATA_W-1:0]     w_rd_data;
  logic                  d_rd_en;
  logic [RC_W-1:0]       d_rd_row;
  logic [RC_W-1:0]       d_rd_idx;
  logic [DATA_W-1:0]     d_rd_data;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*DATA_W-1:0]   res_data;
  logic [RC_W-1:0]       res_row;
  logic [RC_W-1:0]       res_col;
  logic [RC_W-1:0]       res_idx;
  logic                  res_last;

  modport slave (
    input  req_valid, req_row, req_col, w_rd_data, d_rd_data, res_ready,
    output req_ready, req_err, w_rd_en, w_rd_row, w_rd_col,
           d_rd_en, d_rd_row, d_rd_idx,
           res_valid, res_data, res_row, res_col, res_idx, res_last
  );

  modport master (
    output req_valid, req_row, req_col, w_rd_data, d_rd_data, res_ready,
    input  req_ready, req_err, w_rd_en, w_rd_row, w_rd_col,
           d_rd_en, d_rd_row, d_rd_idx,
           res_valid, res_data, res_row, res_col, res_idx, res_last
  );
endinterface

// File: rtl/recompute_unit.sv
// Recomputes one faulty PE: reads W[row][col] once, streams D[row][k]*W for k=0..COLS-1.
// First result 4 cycles after accept, 3 cycles per element; a stalled result holds until res_ready.
module recompute_unit #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int RC_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             busy,
  recompute_unit_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_WRD, S_DRD, S_MUL, S_OUT} state_t;

  localparam logic [RC_W-1:0] ROW_MAX = RC_W'(ROWS - 1);
  localparam logic [RC_W-1:0] COL_MAX = RC_W'(COLS - 1);

  state_t                     state_q, state_d;
  logic [RC_W-1:0]            row_q, col_q, k_q;
  logic signed [DATA_W-1:0]   w_q;
  logic signed [DATA_W-1:0]   d_s;
  logic signed [2*DATA_W-1:0] prod;
  logic                       in_range;
  logic                       last_k;

  assign in_range = (bus.req_row <= ROW_MAX) && (bus.req_col <= COL_MAX);
  assign last_k   = (k_q == COL_MAX);
  assign d_s      = bus.d_rd_data;
  assign prod     = (2*DATA_W)'(d_s) * (2*DATA_W)'(w_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid && in_range) state_d = S_WRD;
      S_WRD:   state_d = S_DRD;
      S_DRD:   state_d = S_MUL;
      S_MUL:   state_d = S_OUT;
      S_OUT:   if (bus.res_ready) state_d = last_k ? S_IDLE : S_DRD;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Read addresses are gated by their strobes so the buffers see zeros when idle.
  always_comb begin
    bus.req_ready = (state_q == S_IDLE) && !flush;
    bus.w_rd_en   = (state_q == S_WRD);
    bus.w_rd_row  = bus.w_rd_en ? row_q : '0;
    bus.w_rd_col  = bus.w_rd_en ? col_q : '0;
    bus.d_rd_en   = (state_q == S_DRD);
    bus.d_rd_row  = bus.d_rd_en ? row_q : '0;
    bus.d_rd_idx  = bus.d_rd_en ? k_q   : '0;
    busy          = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q         <= '0;
      col_q         <= '0;
      k_q           <= '0;
      w_q           <= '0;
      bus.req_err   <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_row   <= '0;
      bus.res_col   <= '0;
      bus.res_idx   <= '0;
      bus.res_last  <= 1'b0;
    end else begin
      bus.req_err <= 1'b0;
      if (flush) begin
        k_q           <= '0;
        bus.res_valid <= 1'b0;
        bus.res_last  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.req_valid) begin
              row_q       <= bus.req_row;
              col_q       <= bus.req_col;
              k_q         <= '0;
              bus.req_err <= !in_range;
            end
          end
          // k is 0 only on the DRD pass that directly follows the weight read.
          S_DRD: if (k_q == '0) w_q <= bus.w_rd_data;
          S_MUL: begin
            bus.res_data  <= prod;
            bus.res_row   <= row_q;
            bus.res_col   <= col_q;
            bus.res_idx   <= k_q;
            bus.res_last  <= last_k;
            bus.res_valid <= 1'b1;
          end
          S_OUT: begin
            if (bus.res_ready) begin
              bus.res_valid <= 1'b0;
              bus.res_last  <= 1'b0;
              if (!last_k) k_q <= k_q + RC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_recompute_unit.sv
// Directed bench for recompute_unit: expected results are queued at issue and
// popped by an independent monitor on every result handshake.
module tb_recompute_unit;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic busy;

  int checks = 0;
  int failures = 0;
  int results = 0;
  int wreads = 0;
  int dreads = 0;

  exp_t exp_q[$];
  logic [7:0] wmem [0:3][0:3];
  logic [7:0] dmem [0:3][0:3];

  recompute_unit_if #(.DATA_W(8), .RC_W(4)) bus ();

  recompute_unit #(.ROWS(4), .COLS(4), .DATA_W(8), .RC_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Weight/data buffers: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.w_rd_en) begin
      bus.w_rd_data <= wmem[bus.w_rd_row[1:0]][bus.w_rd_col[1:0]];
      wreads <= wreads + 1;
    end
    if (bus.d_rd_en) begin
      bus.d_rd_data <= dmem[bus.d_rd_row[1:0]][bus.d_rd_idx[1:0]];
      dreads <= dreads + 1;
    end
  end

  // Monitor: scoreboard pop on handshake, stability check while stalled.
  logic stall_q = 1'b0;
  logic stall_flush_q = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    if (!rst) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q && !stall_flush_q) begin
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== held.data || bus.res_idx !== held.idx ||
            bus.res_row !== held.row || bus.d_rd_en !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold: valid=%b data=%h idx=%0d d_rd_en=%b, required valid=1 data=%h idx=%0d d_rd_en=0",
                   bus.res_valid, bus.res_data, bus.res_idx, bus.d_rd_en, held.data, held.idx);
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        exp_t e;
        checks++;
        results++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL result_unexpected: data=%h idx=%0d, no result expected", bus.res_data, bus.res_idx);
        end else begin
          e = exp_q.pop_front();
          if (bus.res_data !== e.data || bus.res_row !== e.row || bus.res_col !== e.col ||
              bus.res_idx !== e.idx || bus.res_last !== e.last) begin
            failures++;
            $display("FAIL result: got data=%h row=%0d col=%0d idx=%0d last=%b, required data=%h row=%0d col=%0d idx=%0d last=%b",
                     bus.res_data, bus.res_row, bus.res_col, bus.res_idx, bus.res_last,
                     e.data, e.row, e.col, e.idx, e.last);
          end
        end
      end
      stall_q         <= bus.res_valid && !bus.res_ready;
      stall_flush_q   <= flush;
      held.data       <= bus.res_data;
      held.row        <= bus.res_row;
      held.col        <= bus.res_col;
      held.idx        <= bus.res_idx;
      held.last       <= bus.res_last;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] r, input logic [3:0] c, input logic [3:0] i, input logic [15:0] d);
    exp_t e;
    e.data = d; e.row = r; e.col = c; e.idx = i; e.last = (i == 4'd3);
    exp_q.push_back(e);
  endtask

  task automatic send_req(input logic [3:0] r, input logic [3:0] c);
    int n = 0;
    logic acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_row = r;
    bus.req_col = c;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.req_ready;
      tick();
      n++;
    end
    bus.req_valid = 1'b0;
    chk("req_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_res_idx(input logic [3:0] i);
    int n = 0;
    while (!(bus.res_valid && bus.res_idx == i) && n < 100) begin
      tick();
      n++;
    end
    chk("wait_res_idx", {31'd0, bus.res_valid}, 32'd1);
  endtask

  initial begin
    int n, first, last_n, busy_cnt, w0, d0;
    bus.req_valid = 1'b0;
    bus.req_row = '0;
    bus.req_col = '0;
    bus.res_ready = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wmem[r][c] = 8'd0;
        dmem[r][c] = 8'd0;
      end
    wmem[1][2] = 8'd3;
    dmem[1][0] = 8'd1; dmem[1][1] = 8'd2; dmem[1][2] = 8'hFF; dmem[1][3] = 8'd5;
    wmem[0][0] = 8'h80; wmem[0][1] = 8'd127;
    dmem[0][0] = 8'h80; dmem[0][1] = 8'd1; dmem[0][2] = 8'd127; dmem[0][3] = 8'hFF;
    wmem[2][3] = 8'hFD;
    dmem[2][0] = 8'd10; dmem[2][1] = 8'hEC; dmem[2][2] = 8'd0; dmem[2][3] = 8'd7;
    wmem[3][3] = 8'd2;
    dmem[3][0] = 8'd1; dmem[3][1] = 8'd2; dmem[3][2] = 8'd3; dmem[3][3] = 8'd4;

    // Reset state
    #3;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_en", {30'd0, bus.w_rd_en, bus.d_rd_en}, 32'd0);
    chk("rst_res_data", {16'd0, bus.res_data}, 32'd0);
    chk("rst_req_err", {31'd0, bus.req_err}, 32'd0);
    #24;
    rst = 1'b1;
    tick();

    // Basic stream with latency measurement
    push(1, 2, 0, 16'd3); push(1, 2, 1, 16'd6); push(1, 2, 2, 16'hFFFD); push(1, 2, 3, 16'd15);
    w0 = wreads;
    bus.req_valid = 1'b1; bus.req_row = 4'd1; bus.req_col = 4'd2;
    n = 0; first = 0; last_n = 0; busy_cnt = 0;
    while (n < 40 && !(n > 1 && !busy)) begin
      @(negedge clk);
      if (n > 0 && bus.res_valid && bus.res_ready && bus.res_last) last_n = n;
      @(posedge clk); #1;
      n++;
      if (n == 1) bus.req_valid = 1'b0;
      if (busy) busy_cnt++;
      if (bus.res_valid && first == 0) first = n;
    end
    chk("first_res_latency", first, 4);
    chk("last_handshake_cycle", last_n, 13);
    chk("busy_cycles", busy_cnt, 13);
    chk("weight_reads_basic", wreads - w0, 1);

    // Signed extremes
    push(0, 0, 0, 16'h4000); push(0, 0, 1, 16'hFF80); push(0, 0, 2, 16'hC080); push(0, 0, 3, 16'h0080);
    send_req(0, 0);
    wait_idle();
    push(0, 1, 0, 16'hC080); push(0, 1, 1, 16'h007F); push(0, 1, 2, 16'h3F01); push(0, 1, 3, 16'hFF81);
    send_req(0, 1);
    wait_idle();

    // Backpressure: 5-cycle stall on idx 1
    push(1, 2, 0, 16'd3); push(1, 2, 1, 16'd6); push(1, 2, 2, 16'hFFFD); push(1, 2, 3, 16'd15);
    bus.res_ready = 1'b0;
    send_req(1, 2);
    wait_res_idx(0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    wait_res_idx(1);
    d0 = dreads;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_no_dread", dreads - d0, 0);
    chk("stall_idx", {28'd0, bus.res_idx}, 32'd1);
    bus.res_ready = 1'b1;
    wait_idle();

    // Out-of-range request
    w0 = wreads;
    bus.req_valid = 1'b1; bus.req_row = 4'd4; bus.req_col = 4'd0;
    tick();
    bus.req_valid = 1'b0;
    chk("oor_req_err", {31'd0, bus.req_err}, 32'd1);
    chk("oor_busy", {31'd0, busy}, 32'd0);
    chk("oor_req_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    chk("oor_err_pulse", {31'd0, bus.req_err}, 32'd0);
    chk("oor_no_wread", wreads - w0, 0);
    push(0, 0, 0, 16'h4000); push(0, 0, 1, 16'hFF80); push(0, 0, 2, 16'hC080); push(0, 0, 3, 16'h0080);
    send_req(0, 0);
    wait_idle();

    // Flush while idx 2 sits in OUT
    push(1, 2, 0, 16'd3); push(1, 2, 1, 16'd6);
    send_req(1, 2);
    wait_res_idx(2);
    bus.res_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_req_err", {31'd0, bus.req_err}, 32'd0);
    bus.res_ready = 1'b1;
    push(3, 3, 0, 16'd2); push(3, 3, 1, 16'd4); push(3, 3, 2, 16'd6); push(3, 3, 3, 16'd8);
    send_req(3, 3);
    wait_idle();

    // Async reset during DRD, then back-to-back requests
    send_req(2, 3);
    tick();
    chk("pre_rst_drd", {31'd0, bus.d_rd_en}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_d_rd_en", {31'd0, bus.d_rd_en}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    push(0, 1, 0, 16'hC080); push(0, 1, 1, 16'h007F); push(0, 1, 2, 16'h3F01); push(0, 1, 3, 16'hFF81);
    push(2, 3, 0, 16'hFFE2); push(2, 3, 1, 16'h003C); push(2, 3, 2, 16'h0000); push(2, 3, 3, 16'hFFEB);
    send_req(0, 1);
    send_req(2, 3);
    wait_idle();
    tick();
    tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("result_count", results, 34);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
